// File: rtl/shift_left_arb.sv
// Round-robin arbiter sharing one combinational shifter (y = a << n) among
// NREQ requesters; the winning result is registered with its requester ID.

module shift_left #(
  parameter int DIW = 4,
  parameter int SW  = $clog2(DIW),
  parameter int DOW = 2*DIW-1
) (
  input  logic [DIW-1:0] a,
  input  logic [SW-1:0]  n,
  output logic [DOW-1:0] y
);
  assign y = DOW'(a) << n;
endmodule

module shift_left_arb #(
  parameter int DIW  = 4,
  parameter int SW   = $clog2(DIW),
  parameter int DOW  = 2*DIW-1,
  parameter int NREQ = 3,
  parameter int IDW  = (NREQ > 1 ? $clog2(NREQ) : 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DIW-1:0] req_a,
  input  logic [NREQ*SW-1:0]  req_n,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DOW-1:0]      rsp_y,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  logic           vld_p1;
  logic [DOW-1:0] y_p1;
  logic [IDW-1:0] id_p1;
  logic [IDW-1:0] ptr;

  logic           found;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] ptr_nxt;
  logic [DIW-1:0] sel_a;
  logic [SW-1:0]  sel_n;
  logic [DOW-1:0] shift_y;
  logic           can_accept;
  logic           accept;
  int             idx;

  assign can_accept = !vld_p1 || rsp_ready;

  // Stage p0: rotating priority scan starting at ptr, operand mux of the winner
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sel_a = '0;
    sel_n = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
        sel_a = req_a[idx*DIW +: DIW];
        sel_n = req_n[idx*SW +: SW];
      end
    end
  end

  assign ptr_nxt = (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
  assign accept  = found && can_accept;

  // Ready is forced low while reset is asserted even though flops are cleared.
  assign req_ready = (accept && rst_n) ? (NREQ'(1) << gidx) : '0;

  shift_left #(.DIW(DIW), .SW(SW), .DOW(DOW)) u_shift (
    .a (sel_a),
    .n (sel_n),
    .y (shift_y)
  );

  // Stage p1: result register, held under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      y_p1   <= '0;
      id_p1  <= '0;
      ptr    <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      y_p1   <= shift_y;
      id_p1  <= gidx;
      ptr    <= ptr_nxt;
    end else if (rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_y     = y_p1;
  assign rsp_id    = id_p1;
  assign busy      = vld_p1;

endmodule

// File: tb/tb_shift_left_arb.sv
// Self-checking bench for shift_left_arb: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.

module tb_shift_left_arb;
  localparam int DIW  = 4;
  localparam int SW   = 2;
  localparam int DOW  = 7;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DIW-1:0] req_a;
  logic [NREQ*SW-1:0]  req_n;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DOW-1:0]      rsp_y;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  shift_left_arb #(.DIW(DIW), .SW(SW), .DOW(DOW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_n     (req_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending result and round-robin pointer
  int m_ptr = 0;
  bit m_vld = 0;
  int m_y   = 0;
  int m_id  = 0;
  bit m_acc = 0;
  int m_g   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_vld = 0; m_y = 0; m_id = 0; m_acc = 0;
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int n);
    req_valid[i]           = v;
    req_a[i*DIW +: DIW]    = DIW'(a);
    req_n[i*SW +: SW]      = SW'(n);
  endtask

  // One clock: check handshake mid-cycle, advance model at the edge, check outputs after it
  task automatic cycle(input string tag);
    int g;
    bit can;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = pick_winner();
    can = !m_vld || rsp_ready;
    exp_rdy = (g >= 0 && can) ? NREQ'(1 << g) : '0;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(m_vld));
    @(posedge clk);
    m_acc = (g >= 0) && can;
    if (m_acc) begin
      m_g   = g;
      m_vld = 1;
      m_y   = int'(req_a[g*DIW +: DIW]) * (2 ** int'(req_n[g*SW +: SW]));
      m_id  = g;
      m_ptr = (g + 1) % NREQ;
    end else if (m_vld && rsp_ready) begin
      m_vld = 0;
    end
    #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_vld));
    if (m_vld) begin
      chk({tag, ".rsp_y"}, 32'(rsp_y), 32'(m_y));
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(m_id));
    end
  endtask

  initial begin
    logic [DOW-1:0] held_y;
    logic [IDW-1:0] held_id;

    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_n = '0; rsp_ready = 1'b1;
    set_req(0, 1, 4'hA, 1); set_req(1, 1, 4'h3, 2); set_req(2, 1, 4'h7, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rsp_valid", 32'(rsp_valid), 0);
    chk("reset.rsp_y", 32'(rsp_y), 0);
    chk("reset.rsp_id", 32'(rsp_id), 0);
    chk("reset.req_ready", 32'(req_ready), 0);
    req_valid = '0;
    model_reset();
    rst_n = 1'b1;

    // Single request, then skipping idle requesters
    set_req(0, 1, 4'b1011, 2);
    cycle("single");
    chk("single.y44", 32'(rsp_y), 32'd44);
    req_valid = 3'b100; set_req(2, 1, 4'h5, 1);
    cycle("skip2");
    chk("skip2.id", 32'(rsp_id), 2);
    req_valid = 3'b010; set_req(1, 1, 4'h9, 3);
    cycle("skip1");
    chk("skip1.id", 32'(rsp_id), 1);
    req_valid = '0;
    cycle("drain");

    // Saturated fairness from reset: ids 0,1,2,0,1,2 back to back
    rst_n = 1'b0; #2; rst_n = 1'b1; model_reset();
    set_req(0, 1, 4'h1, 0); set_req(1, 1, 4'h2, 1); set_req(2, 1, 4'h3, 2);
    for (int c = 0; c < 6; c++) begin
      cycle("fair");
      chk("fair.id", 32'(rsp_id), 32'(c % NREQ));
    end
    req_valid = '0;
    cycle("drain2");

    // Maximum shift and zero shift
    set_req(0, 1, 4'hF, 3);
    cycle("maxshift");
    chk("maxshift.y", 32'(rsp_y), 32'h78);
    req_valid = '0; set_req(1, 1, 4'h1, 0);
    cycle("zeroshift");
    chk("zeroshift.y", 32'(rsp_y), 32'h01);
    req_valid = '0;
    cycle("drain3");

    // Backpressure: pending 44 held while everyone requests
    set_req(m_ptr, 1, 4'b1011, 2);
    cycle("bp.load");
    chk("bp.y44", 32'(rsp_y), 32'd44);
    held_y = rsp_y; held_id = rsp_id;
    rsp_ready = 1'b0; req_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      cycle("bp.hold");
      chk("bp.y_stable", 32'(rsp_y), 32'(held_y));
      chk("bp.id_stable", 32'(rsp_id), 32'(held_id));
    end
    rsp_ready = 1'b1;
    cycle("bp.release");

    // Asynchronous reset while a result is pending under backpressure
    rsp_ready = 1'b0;
    cycle("rst.prep");
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.rsp_valid", 32'(rsp_valid), 0);
    chk("rstmid.rsp_y", 32'(rsp_y), 0);
    chk("rstmid.rsp_id", 32'(rsp_id), 0);
    chk("rstmid.req_ready", 32'(req_ready), 0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    rsp_ready = 1'b1; req_valid = 3'b111;
    cycle("rstmid.after");
    chk("rstmid.first_id", 32'(rsp_id), 0);

    // Randomized traffic; requesters hold operands until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || (m_acc && m_g == i))
          set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
